mul_sequencer: RTL and testbench

- Multi-cycle sequencer that executes ARM MUL/MLA on the shared 32-bit ALU using iterative shift-and-add.
- Each iteration issues the ALU ADD opcode (5'b00100).
- Sits beside the control unit. The CU pulses start, holds off instruction issue while busy is high, then writes result and optional NZ flags on done.
- ALU access is requested per cycle, so the ALU can be shared with the CU.

---
 rtl/mul_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mul_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Iterative shift-and-add MUL/MLA sequencer that borrows the shared ALU one ADD per cycle.
// The control unit pulses start, stalls issue while busy, and writes result/NZ flags on done.
module mul_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CNT_W  = 5,
    parameter logic [4:0]  OP_ADD = 5'b00100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             accumulate,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] rm,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rn,
    input  logic [3:0]       flags_in,
    input  logic             alu_gnt,
    input  logic [WIDTH-1:0] alu_o,
    output logic             alu_req,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_op,
    output logic             alu_cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out,
    output logic             flags_we
);

    localparam int unsigned OP_W   = 5;
    localparam int unsigned FLAG_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sf_q, sf_d;
    logic [1:0]         cv_q, cv_d;

    logic               alu_req_q, alu_req_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]    alu_op_q, alu_op_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [FLAG_W-1:0]  flags_out_q, flags_out_d;
    logic               flags_we_q, flags_we_d;

    // N and Z are recomputed here; only C and V are carried from the instruction
    logic               unused_flags;
    assign unused_flags = ^flags_in[3:2];

    // Next-state and next-output logic; outputs are derived from the state being entered
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        sf_d        = sf_q;
        cv_d        = cv_q;
        result_d    = result_q;
        flags_out_d = flags_out_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d    = accumulate ? rn : '0;
                    mcand_d  = rm;
                    mplier_d = rs;
                    cnt_d    = '0;
                    sf_d     = set_flags;
                    cv_d     = flags_in[1:0];
                    state_d  = S_ITER;
                end
            end
            S_ITER: begin
                if (alu_gnt) begin
                    if (mplier_q[0]) begin
                        acc_d = alu_o;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    // Stop once no multiplier bits remain, or after the final bit position
                    if ((mplier_q[WIDTH-1:1] == '0) || (cnt_q == CNT_W'(WIDTH - 1))) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        flags_we_d = (state_d == S_DONE) && sf_d;
        alu_req_d  = (state_d == S_ITER);
        alu_a_d    = (state_d == S_ITER) ? acc_d : '0;
        alu_b_d    = (state_d == S_ITER) ? mcand_d : '0;
        alu_op_d   = (state_d == S_ITER) ? OP_ADD : '0;

        if (state_d == S_DONE) begin
            result_d    = acc_d;
            flags_out_d = {acc_d[WIDTH-1], (acc_d == '0), cv_d};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            sf_q        <= 1'b0;
            cv_q        <= '0;
            alu_req_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            flags_out_q <= '0;
            flags_we_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            sf_q        <= sf_d;
            cv_q        <= cv_d;
            alu_req_q   <= alu_req_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            flags_out_q <= flags_out_d;
            flags_we_q  <= flags_we_d;
        end
    end

    assign alu_req   = alu_req_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign alu_cin   = 1'b0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign flags_out = flags_out_q;
    assign flags_we  = flags_we_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed-vector bench for mul_sequencer with a behavioural adder standing in for the shared ALU.
module tb_mul_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        accumulate;
    logic        set_flags;
    logic [31:0] rm;
    logic [31:0] rs;
    logic [31:0] rn;
    logic [3:0]  flags_in;
    logic        alu_gnt;
    logic [31:0] alu_o;
    logic        alu_req;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic        alu_cin;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  flags_out;
    logic        flags_we;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] tr_a    [0:127];
    logic [31:0] tr_b    [0:127];
    logic        tr_req  [0:127];
    logic        tr_busy [0:127];
    logic [4:0]  tr_op   [0:127];

    mul_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .accumulate (accumulate),
        .set_flags  (set_flags),
        .rm         (rm),
        .rs         (rs),
        .rn         (rn),
        .flags_in   (flags_in),
        .alu_gnt    (alu_gnt),
        .alu_o      (alu_o),
        .alu_req    (alu_req),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_cin    (alu_cin),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .flags_out  (flags_out),
        .flags_we   (flags_we)
    );

    assign alu_o = alu_a + alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Launch one operation and step cycles until done; cycle 0 is the start cycle
    task automatic run_op(input logic [31:0] a_rm, input logic [31:0] a_rs, input logic [31:0] a_rn,
                          input logic a_acc, input logic a_sf, input logic [3:0] a_fl,
                          input int deny_lo, input int deny_hi, input int repulse_at,
                          output int dcyc);
        int cyc;
        @(negedge clk);
        start      = 1'b1;
        rm         = a_rm;
        rs         = a_rs;
        rn         = a_rn;
        accumulate = a_acc;
        set_flags  = a_sf;
        flags_in   = a_fl;
        alu_gnt    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 100) begin
            tr_a[cyc]    = alu_a;
            tr_b[cyc]    = alu_b;
            tr_req[cyc]  = alu_req;
            tr_busy[cyc] = busy;
            tr_op[cyc]   = alu_op;
            alu_gnt = !(cyc >= deny_lo && cyc <= deny_hi);
            if (cyc == repulse_at) begin
                start = 1'b1;
                rm    = 32'd100;
                rs    = 32'd100;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start   = 1'b0;
        alu_gnt = 1'b1;
        dcyc    = cyc;
    endtask

    // One cycle after done the block must be idle with the ALU released and result held
    task automatic check_idle_after(input string tag, input logic [31:0] exp_res);
        @(negedge clk);
        check_eq({tag, "_busy_drop"}, 32'(busy), 32'd0);
        check_eq({tag, "_done_drop"}, 32'(done), 32'd0);
        check_eq({tag, "_req_idle"},  32'(alu_req), 32'd0);
        check_eq({tag, "_a_idle"},    alu_a, 32'd0);
        check_eq({tag, "_res_hold"},  result, exp_res);
    endtask

    initial begin
        int  d;
        logic seen_done;

        reset_n    = 1'b0;
        start      = 1'b0;
        accumulate = 1'b0;
        set_flags  = 1'b0;
        rm         = '0;
        rs         = '0;
        rn         = '0;
        flags_in   = '0;
        alu_gnt    = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_busy",   32'(busy), 32'd0);
        check_eq("rst_done",   32'(done), 32'd0);
        check_eq("rst_req",    32'(alu_req), 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_flags",  32'(flags_out), 32'd0);
        check_eq("rst_cin",    32'(alu_cin), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // MUL 6*7: three iterations
        run_op(32'd6, 32'd7, 32'd0, 1'b0, 1'b0, 4'b0000, -1, -1, -1, d);
        check_eq("t1_lat",    32'(d), 32'd4);
        check_eq("t1_result", result, 32'd42);
        check_eq("t1_we",     32'(flags_we), 32'd0);
        check_eq("t1_flags",  32'(flags_out), 32'h0);
        check_eq("t1_busy1",  32'(tr_busy[1]), 32'd1);
        check_eq("t1_req1",   32'(tr_req[1]), 32'd1);
        check_eq("t1_op1",    32'(tr_op[1]), 32'h4);
        check_idle_after("t1", 32'd42);

        // MLA with rs=0: single iteration, Z set, C/V carried through
        run_op(32'd5, 32'd0, 32'd0, 1'b1, 1'b1, 4'b0011, -1, -1, -1, d);
        check_eq("t2_lat",    32'(d), 32'd2);
        check_eq("t2_result", result, 32'd0);
        check_eq("t2_flags",  32'(flags_out), 32'b0111);
        check_eq("t2_we",     32'(flags_we), 32'd1);
        check_idle_after("t2", 32'd0);

        // Top multiplier bit only: full 32 iterations
        run_op(32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 4'b0000, -1, -1, -1, d);
        check_eq("t3_lat",    32'(d), 32'd33);
        check_eq("t3_result", result, 32'h8000_0000);
        check_eq("t3_flags",  32'(flags_out), 32'b1000);
        check_eq("t3_we",     32'(flags_we), 32'd1);

        // All-ones operands wrap modulo 2^32
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 4'b0000, -1, -1, -1, d);
        check_eq("t4_lat",    32'(d), 32'd33);
        check_eq("t4_result", result, 32'h0000_0001);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'b1010, -1, -1, -1, d);
        check_eq("t4m_result", result, 32'h0000_0000);
        check_eq("t4m_flags",  32'(flags_out), 32'b0110);

        // Grant withheld for cycles 2-3: accumulator frozen, two extra cycles
        run_op(32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 4'b0000, 2, 3, -1, d);
        check_eq("t5_lat",    32'(d), 32'd5);
        check_eq("t5_result", result, 32'd9);
        check_eq("t5_a1",     tr_a[1], 32'd0);
        check_eq("t5_b1",     tr_b[1], 32'd3);
        check_eq("t5_a2",     tr_a[2], 32'd3);
        check_eq("t5_a3",     tr_a[3], 32'd3);
        check_eq("t5_b3",     tr_b[3], 32'd6);

        // start re-pulsed mid-operation is ignored
        run_op(32'd6, 32'd7, 32'd0, 1'b0, 1'b0, 4'b0000, -1, -1, 2, d);
        check_eq("t6_lat",    32'(d), 32'd4);
        check_eq("t6_result", result, 32'd42);
        check_idle_after("t6", 32'd42);

        // Reset in the middle of an 8-iteration operation
        @(negedge clk);
        start = 1'b1;
        rm    = 32'd3;
        rs    = 32'hFF;
        accumulate = 1'b0;
        set_flags  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t7_busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("t7_busy",   32'(busy), 32'd0);
        check_eq("t7_done",   32'(done), 32'd0);
        check_eq("t7_req",    32'(alu_req), 32'd0);
        check_eq("t7_a",      alu_a, 32'd0);
        check_eq("t7_b",      alu_b, 32'd0);
        check_eq("t7_op",     32'(alu_op), 32'd0);
        check_eq("t7_result", result, 32'd0);
        check_eq("t7_flags",  32'(flags_out), 32'd0);
        check_eq("t7_we",     32'(flags_we), 32'd0);
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        reset_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        check_eq("t7_no_done", 32'(seen_done), 32'd0);
        check_eq("t7_idle",    32'(busy), 32'd0);
        run_op(32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 4'b0000, -1, -1, -1, d);
        check_eq("t7_lat",     32'(d), 32'd3);
        check_eq("t7_fresh",   result, 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
